// File: rtl/display_scan_ctrl.sv
// Scan controller for a bank of common-anode 7-segment digits sharing one decoder.
// Holds an active frame of BCD codes and presents one digit per refresh slot,
// with an anode-off guard at the start of each slot. New frames arrive through a
// one-deep pending buffer and are applied only at frame boundaries.
module display_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 16,
  parameter int LZ_BLANK    = 1,
  localparam int IDX_W      = $clog2(NUM_DIGITS),
  localparam int CNT_W      = $clog2(REFRESH_DIV)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  output logic [3:0]              digit_code,
  output logic [NUM_DIGITS-1:0]   anodes_n,
  output logic [IDX_W-1:0]        digit_idx
);

  logic [CNT_W-1:0]           r_slot_cnt;
  logic [IDX_W-1:0]           r_digit_idx;
  logic [NUM_DIGITS-1:0][3:0] r_active;
  logic [NUM_DIGITS-1:0][3:0] r_pending;
  logic                       r_pend_full;
  logic                       r_ready;
  logic [3:0]                 r_digit_code;
  logic [NUM_DIGITS-1:0]      r_anodes_n;

  logic                       w_xfer;
  logic                       w_slot_end;
  logic                       w_last_digit;
  logic                       w_boundary;
  logic                       w_pend_full_nxt;
  logic                       w_gap;
  logic [NUM_DIGITS-1:0]      w_blank;
  logic [NUM_DIGITS-1:0]      w_anodes_nxt;

  assign w_xfer       = load_valid && r_ready;
  assign w_slot_end   = (r_slot_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_last_digit = (r_digit_idx == IDX_W'(NUM_DIGITS - 1));
  // Disabling counts as a boundary so a pending frame is never stranded while dark.
  assign w_boundary   = !enable || (w_slot_end && w_last_digit);
  assign w_gap        = (r_slot_cnt < CNT_W'(GAP_CYCLES));

  // A boundary drains pending; a transfer in the same cycle can only happen when
  // pending was already empty, so it simply refills it.
  assign w_pend_full_nxt = w_xfer ? 1'b1 : (w_boundary ? 1'b0 : r_pend_full);

  // Leading-zero blanking: digit k dark when it and every higher digit are zero.
  // Digit 0 always shows so a zero frame still reads "0".
  assign w_blank[0] = 1'b0;
  for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_blank
    assign w_blank[k] = (LZ_BLANK != 0) && (r_active[NUM_DIGITS-1:k] == '0);
  end

  // Anode for the scanned digit goes low only in the ON part of the slot.
  always_comb begin
    w_anodes_nxt = '1;
    if (enable && !w_gap && !w_blank[r_digit_idx])
      w_anodes_nxt[r_digit_idx] = 1'b0;
  end

  // Slot/digit counters, handshake buffer and frame swap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot_cnt  <= '0;
      r_digit_idx <= '0;
      r_active    <= '0;
      r_pending   <= '0;
      r_pend_full <= 1'b0;
      r_ready     <= 1'b0;
    end else begin
      r_pend_full <= w_pend_full_nxt;
      r_ready     <= ~w_pend_full_nxt;
      if (w_xfer)
        r_pending <= load_data;
      if (w_boundary && r_pend_full)
        r_active <= r_pending;
      if (!enable) begin
        r_slot_cnt  <= '0;
        r_digit_idx <= '0;
      end else if (w_slot_end) begin
        r_slot_cnt  <= '0;
        r_digit_idx <= w_last_digit ? '0 : r_digit_idx + 1'b1;
      end else begin
        r_slot_cnt  <= r_slot_cnt + 1'b1;
      end
    end
  end

  // Registered drive to the decoder and anodes; the code is valid through the
  // guard gap so segments settle before the anode turns on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_digit_code <= 4'd0;
      r_anodes_n   <= '1;
    end else begin
      r_digit_code <= r_active[r_digit_idx];
      r_anodes_n   <= w_anodes_nxt;
    end
  end

  assign load_ready = r_ready;
  assign digit_code = r_digit_code;
  assign anodes_n   = r_anodes_n;
  assign digit_idx  = r_digit_idx;

endmodule
